// File: rtl/stream_mux_rr_if.sv
// Stream bundle for stream_mux_rr: N producer channels in, one stream out.
// slave is the mux side, master is the producer/consumer side.
interface stream_mux_rr_if #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2
);
    logic [CHANNELS*WIDTH-1:0] in_data;
    logic [CHANNELS-1:0]       in_valid;
    logic [CHANNELS-1:0]       in_ready;
    logic [WIDTH-1:0]          out_data;
    logic [SEL_W-1:0]          out_ch;
    logic                      out_valid;
    logic                      out_ready;

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output out_data,
        output out_ch,
        output out_valid,
        input  out_ready
    );

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  out_data,
        input  out_ch,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream mux, fixed-select or round-robin,
// with a one-entry registered output stage.
module stream_mux_rr #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mode,
    input  logic [SEL_W-1:0] sl,
    stream_mux_rr_if.slave   bus
);

    localparam logic [SEL_W-1:0] PTR_RST = SEL_W'(CHANNELS - 1);

    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic [SEL_W-1:0] out_ch_q,    out_ch_d;
    logic             out_valid_q, out_valid_d;
    logic [SEL_W-1:0] rr_ptr_q,    rr_ptr_d;

    logic             fix_hit;
    logic [SEL_W-1:0] fix_idx;
    logic             rr_hit;
    logic [SEL_W-1:0] rr_idx;
    logic             gnt_vld;
    logic [SEL_W-1:0] gnt_idx;
    logic [WIDTH-1:0] gnt_data;
    logic             ld;
    logic             xfer;

    function automatic logic [SEL_W-1:0] rr_slot(
        input logic [SEL_W-1:0] ptr,
        input int               off
    );
        return SEL_W'((int'(ptr) + off) % CHANNELS);
    endfunction

    // Fixed select: out-of-range selects never grant.
    always_comb begin
        fix_hit = 1'b0;
        fix_idx = '0;
        if (int'(sl) < CHANNELS) begin
            fix_idx = sl;
            fix_hit = bus.in_valid[sl];
        end
    end

    // Scan from farthest to nearest so the slot closest
    // after rr_ptr is the one left standing.
    always_comb begin
        rr_hit = 1'b0;
        rr_idx = '0;
        for (int off = CHANNELS; off >= 1; off--) begin
            if (bus.in_valid[rr_slot(rr_ptr_q, off)]) begin
                rr_hit = 1'b1;
                rr_idx = rr_slot(rr_ptr_q, off);
            end
        end
    end

    always_comb begin
        gnt_vld = mode ? rr_hit : fix_hit;
        gnt_idx = mode ? rr_idx : fix_idx;
        ld      = !out_valid_q || bus.out_ready;
        xfer    = rst_n && gnt_vld && ld;
    end

    always_comb begin
        gnt_data = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (gnt_idx == SEL_W'(i)) begin
                gnt_data = bus.in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        bus.in_ready = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (gnt_idx == SEL_W'(i)) begin
                bus.in_ready[i] = xfer;
            end
        end
    end

    always_comb begin
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_valid_d = out_valid_q;
        rr_ptr_d    = rr_ptr_q;
        if (xfer) begin
            out_data_d  = gnt_data;
            out_ch_d    = gnt_idx;
            out_valid_d = 1'b1;
            rr_ptr_d    = gnt_idx;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
            rr_ptr_q    <= PTR_RST;
        end else begin
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_ch    = out_ch_q;
    assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr: fixed select, round-robin,
// backpressure, wrap-around and asynchronous reset.
module tb_stream_mux_rr;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       mode;
    logic [1:0] sl;
    int         n_asrt = 0;
    int         n_fail = 0;

    stream_mux_rr_if #(.WIDTH(8), .CHANNELS(4), .SEL_W(2)) bus ();

    stream_mux_rr #(.WIDTH(8), .CHANNELS(4), .SEL_W(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .mode  (mode),
        .sl    (sl),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v,
                           input logic [7:0] d, input logic [1:0] c);
        chk({tag, ".valid"}, 32'(bus.out_valid), 32'(v));
        chk({tag, ".data"},  32'(bus.out_data),  32'(d));
        chk({tag, ".ch"},    32'(bus.out_ch),    32'(c));
    endtask

    initial begin
        logic [1:0] seq [6];
        logic [7:0] dat [4];
        seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

        // Reset with every channel requesting: no ready may leak out
        rst_n         = 1'b0;
        mode          = 1'b1;
        sl            = 2'd0;
        bus.in_data   = {8'h13, 8'hA5, 8'h11, 8'h10};
        bus.in_valid  = 4'b1111;
        bus.out_ready = 1'b0;
        dat           = '{8'h10, 8'h11, 8'hA5, 8'h13};
        #2;
        chk("rst.in_ready", 32'(bus.in_ready), 32'h0);
        chk_out("rst", 1'b0, 8'h00, 2'd0);
        step();
        step();
        bus.in_valid = 4'b0000;
        rst_n        = 1'b1;
        step();

        // 1: fixed select of channel 2
        mode          = 1'b0;
        sl            = 2'd2;
        bus.in_valid  = 4'b0100;
        bus.out_ready = 1'b1;
        #1;
        chk("fix.in_ready", 32'(bus.in_ready), 32'b0100);
        step();
        chk_out("fix", 1'b1, 8'hA5, 2'd2);

        // 2: selected channel idle, other channel valid
        sl           = 2'd1;
        bus.in_valid = 4'b1000;
        #1;
        chk("unsel.in_ready", 32'(bus.in_ready), 32'h0);
        step();
        chk_out("unsel", 1'b0, 8'hA5, 2'd2);

        // 5: rr_ptr still 2, so search 3,0,1 -> ch1 (not ch2)
        mode         = 1'b1;
        bus.in_valid = 4'b0110;
        #1;
        chk("ptr_kept.in_ready", 32'(bus.in_ready), 32'b0010);
        bus.in_valid = 4'b0010;
        #1;
        chk("wrap.in_ready", 32'(bus.in_ready), 32'b0010);
        step();
        chk_out("wrap", 1'b1, 8'h11, 2'd1);

        // Park rr_ptr at 3 through a fixed-mode transfer
        mode         = 1'b0;
        sl           = 2'd3;
        bus.in_valid = 4'b1000;
        step();
        chk_out("park", 1'b1, 8'h13, 2'd3);

        // 3: round-robin, all valid, one word per cycle
        mode         = 1'b1;
        bus.in_valid = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk($sformatf("rr%0d.in_ready", k), 32'(bus.in_ready),
                32'(4'b0001 << seq[k]));
            step();
            chk_out($sformatf("rr%0d", k), 1'b1, dat[seq[k]], seq[k]);
        end

        // 4: backpressure on a held 3C word
        mode         = 1'b0;
        sl           = 2'd0;
        bus.in_data  = {8'h13, 8'hA5, 8'h11, 8'h3C};
        bus.in_valid = 4'b0001;
        step();
        chk_out("bp.load", 1'b1, 8'h3C, 2'd0);
        bus.out_ready = 1'b0;
        bus.in_valid  = 4'b0010;
        mode          = 1'b1;
        for (int k = 0; k < 3; k++) begin
            sl   = 2'(k + 1);
            mode = k[0];
            #1;
            chk($sformatf("bp%0d.in_ready", k), 32'(bus.in_ready), 32'h0);
            step();
            chk_out($sformatf("bp%0d", k), 1'b1, 8'h3C, 2'd0);
        end
        mode          = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        chk("bp.release.in_ready", 32'(bus.in_ready), 32'b0010);
        step();
        chk_out("bp.next", 1'b1, 8'h11, 2'd1);
        bus.in_valid = 4'b0000;
        step();
        chk_out("drain", 1'b0, 8'h11, 2'd1);

        // 6: asynchronous reset while a word is held
        bus.in_valid = 4'b0100;
        step();
        chk_out("pre_rst", 1'b1, 8'hA5, 2'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("async_rst", 1'b0, 8'h00, 2'd0);
        chk("async_rst.in_ready", 32'(bus.in_ready), 32'h0);
        step();
        bus.in_valid = 4'b1010;
        rst_n        = 1'b1;
        #1;
        chk("post_rst.in_ready", 32'(bus.in_ready), 32'b0010);
        step();
        chk_out("post_rst", 1'b1, 8'h11, 2'd1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_asrt, n_fail);
        $finish;
    end

endmodule
